// File: rtl/bpsk_pkg.sv
// Shared BPSK constants and types, used by the receiver and the transmitter.
// Carries the sample/symbol geometry, packet framing, sync word, accumulator
// width and the receiver framing FSM state type.
package bpsk_pkg;

  localparam int unsigned DATA_WIDTH         = 12;
  localparam int unsigned SAMPLES_PER_CYCLE  = 32;
  localparam int unsigned SAMPLES_PER_SYMBOL = 32;
  localparam int unsigned PACKET_WIDTH       = 8;
  localparam int unsigned SYNC_WIDTH         = 8;
  localparam logic [SYNC_WIDTH-1:0] SYNC_WORD = 8'hD5;

  localparam int unsigned ACC_WIDTH = DATA_WIDTH + $clog2(SAMPLES_PER_SYMBOL) + 2;
  localparam int unsigned CYC_CNT_W = $clog2(SAMPLES_PER_CYCLE);
  localparam int unsigned SYM_CNT_W = $clog2(SAMPLES_PER_SYMBOL);
  localparam int unsigned BIT_CNT_W = $clog2(PACKET_WIDTH + 1);

  typedef enum logic [1:0] {
    SEARCH,
    PAYLOAD,
    DELIVER
  } rx_state_e;

endpackage

// File: rtl/bpsk_correlator.sv
// Integrate-and-dump BPSK correlator.
// Centers offset-binary samples, multiplies by a +/-1 square reference and
// accumulates over one symbol; emits a registered hard decision per symbol.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sample_in         ADC sample (offset binary)
//   sample_valid      sample qualifier; counters stall when low
//   bit_out           hard decision (acc >= 0 -> 1)
//   bit_valid         one-cycle strobe for bit_out
module bpsk_correlator
  import bpsk_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  bit_out,
  output logic                  bit_valid
);

  logic [CYC_CNT_W-1:0]        car_cnt_q, car_cnt_d;
  logic [SYM_CNT_W-1:0]        sym_cnt_q, sym_cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                        bit_out_q, bit_out_d;
  logic                        bit_valid_q, bit_valid_d;

  logic signed [DATA_WIDTH:0]  centered;
  logic signed [ACC_WIDTH-1:0] centered_ext, term, acc_sum;
  logic                        ref_pos;

  assign centered     = $signed({1'b0, sample_in}) - $signed({2'b01, {(DATA_WIDTH-1){1'b0}}});
  assign centered_ext = {{(ACC_WIDTH-DATA_WIDTH-1){centered[DATA_WIDTH]}}, centered};
  assign ref_pos      = car_cnt_q < CYC_CNT_W'(SAMPLES_PER_CYCLE / 2);
  assign term         = ref_pos ? centered_ext : -centered_ext;
  assign acc_sum      = acc_q + term;

  always_comb begin
    car_cnt_d   = car_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    acc_d       = acc_q;
    bit_out_d   = bit_out_q;
    bit_valid_d = 1'b0;
    if (sample_valid) begin
      car_cnt_d = (car_cnt_q == CYC_CNT_W'(SAMPLES_PER_CYCLE - 1)) ? '0 : car_cnt_q + 1'b1;
      if (sym_cnt_q == SYM_CNT_W'(SAMPLES_PER_SYMBOL - 1)) begin
        // Decide on the sum including this last sample; zero maps to 1.
        sym_cnt_d   = '0;
        acc_d       = '0;
        bit_out_d   = ~acc_sum[ACC_WIDTH-1];
        bit_valid_d = 1'b1;
      end else begin
        sym_cnt_d = sym_cnt_q + 1'b1;
        acc_d     = acc_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      car_cnt_q   <= '0;
      sym_cnt_q   <= '0;
      acc_q       <= '0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      car_cnt_q   <= car_cnt_d;
      sym_cnt_q   <= sym_cnt_d;
      acc_q       <= acc_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign bit_out   = bit_out_q;
  assign bit_valid = bit_valid_q;

endmodule

// File: rtl/bpsk_receiver.sv
// BPSK receiver: correlator plus sync hunt and packet framing.
// Hunts for SYNC_WORD (or its inverse, fixing the 180 degree ambiguity),
// collects PACKET_WIDTH payload bits and presents them on a valid/ready port.
// Optional macro BPSK_RX_DIFF_DECODE_EN: differential decode (bit XOR previous
// raw decision), sync on the decoded stream against SYNC_WORD only.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   sample_in/valid   ADC sample stream
//   packet_out/valid  recovered payload, held until accepted
//   packet_ready      downstream accept
//   bit_out/valid     raw hard decisions (no polarity correction)
//   locked            high while collecting payload bits
//   overrun           one-cycle pulse when a completed packet is dropped
module bpsk_receiver
  import bpsk_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   sample_in,
  input  logic                    sample_valid,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    packet_valid,
  input  logic                    packet_ready,
  output logic                    bit_out,
  output logic                    bit_valid,
  output logic                    locked,
  output logic                    overrun
);

  rx_state_e               state_q, state_d;
  logic [SYNC_WIDTH-1:0]   shift_q, shift_d, shift_next;
  logic                    polarity_q, polarity_d;
  logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PACKET_WIDTH-1:0] payload_q, payload_d;
  logic [PACKET_WIDTH-1:0] packet_q, packet_d;
  logic                    packet_valid_q, packet_valid_d;
  logic                    overrun_q, overrun_d;

  logic corr_bit, corr_bit_valid;
  logic corrected_bit, sync_bit, sync_hit, sync_inv_hit;

  bpsk_correlator u_corr (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .bit_out      (corr_bit),
    .bit_valid    (corr_bit_valid)
  );

`ifdef BPSK_RX_DIFF_DECODE_EN
  logic prev_q;
  always_ff @(posedge clk) begin
    if (rst)                 prev_q <= 1'b0;
    else if (corr_bit_valid) prev_q <= corr_bit;
  end
  // Polarity stays 0 here; the XOR keeps one datapath for both builds.
  assign corrected_bit = corr_bit ^ prev_q ^ polarity_q;
  assign sync_bit      = corrected_bit;
  assign sync_inv_hit  = 1'b0;
`else
  assign corrected_bit = corr_bit ^ polarity_q;
  assign sync_bit      = corr_bit;
  assign sync_inv_hit  = shift_next == ~SYNC_WORD;
`endif

  assign shift_next = {shift_q[SYNC_WIDTH-2:0], sync_bit};
  assign sync_hit   = shift_next == SYNC_WORD;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= SEARCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SEARCH:  if (corr_bit_valid && (sync_hit || sync_inv_hit)) state_d = PAYLOAD;
      PAYLOAD: if (corr_bit_valid && bit_cnt_q == BIT_CNT_W'(PACKET_WIDTH - 1)) state_d = DELIVER;
      DELIVER: state_d = SEARCH;
      default: state_d = SEARCH;
    endcase
  end

  // Output logic
  always_comb begin
    locked = (state_q == PAYLOAD);
  end

  // Framing datapath
  always_comb begin
    shift_d        = shift_q;
    polarity_d     = polarity_q;
    bit_cnt_d      = bit_cnt_q;
    payload_d      = payload_q;
    packet_d       = packet_q;
    packet_valid_d = packet_valid_q;
    overrun_d      = 1'b0;
    if (packet_valid_q && packet_ready) packet_valid_d = 1'b0;
    if (corr_bit_valid) shift_d = shift_next;
    unique case (state_q)
      SEARCH: begin
        if (corr_bit_valid && sync_hit)          polarity_d = 1'b0;
        else if (corr_bit_valid && sync_inv_hit) polarity_d = 1'b1;
      end
      PAYLOAD: begin
        if (corr_bit_valid) begin
          payload_d = {payload_q[PACKET_WIDTH-2:0], corrected_bit};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      DELIVER: begin
        // Accepting in the same cycle frees the slot for the new packet.
        if (!packet_valid_q || packet_ready) begin
          packet_d       = payload_q;
          packet_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
        bit_cnt_d = '0;
        shift_d   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q        <= '0;
      polarity_q     <= 1'b0;
      bit_cnt_q      <= '0;
      payload_q      <= '0;
      packet_q       <= '0;
      packet_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      shift_q        <= shift_d;
      polarity_q     <= polarity_d;
      bit_cnt_q      <= bit_cnt_d;
      payload_q      <= payload_d;
      packet_q       <= packet_d;
      packet_valid_q <= packet_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign packet_out   = packet_q;
  assign packet_valid = packet_valid_q;
  assign overrun      = overrun_q;
  assign bit_out      = corr_bit;
  assign bit_valid    = corr_bit_valid;

endmodule
